// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Parametrised N-phase one-hot sequencer driven by a single-clock prescaler.
// A prescaler tick fires once every 2^PRESCALE_BITS enabled cycles; each phase
// stays active for DWELL_TICKS ticks before the sequence advances forward or in
// reverse. A single-step input advances one phase while the run enable is low.
//
// Parameters:
//   PRESCALE_BITS  prescaler width (0 = a tick on every enabled cycle)
//   NUM_PHASES     number of phases (>= 2)
//   DWELL_TICKS    ticks each phase stays active (>= 1)
//   IDX_W          phase index width, derived from NUM_PHASES
//
// Ports:
//   clk        clock (tile io_in[0])
//   rst        asynchronous reset, active-high
//   en         run enable; low freezes the prescaler and dwell counters
//   dir        0 = forward (idx+1), 1 = reverse (idx-1)
//   step       single-cycle advance request, honoured only while en = 0
//   phase_out  one-hot active phase
//   phase_idx  current phase index
//   tick       registered prescaler tick, one cycle wide
//   wrap       one-cycle pulse when the sequence wraps
//
// Optional feature (macro PHASE_SEQ_BLANK_EN):
//   Every advance inserts a blanking interval of one tick period during which
//   phase_out is all zeros while phase_idx already shows the new phase.
// -----------------------------------------------------------------------------
module phase_sequencer #(
  parameter int PRESCALE_BITS = 16,
  parameter int NUM_PHASES    = 3,
  parameter int DWELL_TICKS   = 1,
  parameter int IDX_W         = $clog2(NUM_PHASES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  step,
  output logic [NUM_PHASES-1:0] phase_out,
  output logic [IDX_W-1:0]      phase_idx,
  output logic                  tick,
  output logic                  wrap
);

  // A zero-width prescaler is modelled as a 1-bit register that never counts.
  localparam int PRE_W   = (PRESCALE_BITS > 0) ? PRESCALE_BITS : 1;
  localparam int DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_PHASES - 1);
  localparam logic [DWELL_W-1:0]    DWELL_LAST = DWELL_W'(DWELL_TICKS - 1);
  localparam logic [NUM_PHASES-1:0] PHASE0     = NUM_PHASES'(1);

  logic [PRE_W-1:0]   prescaler;
  logic [PRE_W-1:0]   prescaler_next;
  logic [DWELL_W-1:0] dwell;
  logic               pre_full;
  logic               tick_now;
  logic               step_now;
  logic               dwell_done;
  logic [IDX_W-1:0]   next_idx;
  logic               wraps;

`ifdef PHASE_SEQ_BLANK_EN
  logic               blank;
`endif

  function automatic logic [NUM_PHASES-1:0] onehot(input logic [IDX_W-1:0] i);
    return PHASE0 << i;
  endfunction

  // Tick/step qualification and the neighbouring phase for the current dir.
  // The index only ever moves by one with explicit wrap to 0 or LAST_IDX, so
  // codes above NUM_PHASES-1 can never be reached.
  always_comb begin
    pre_full       = (PRESCALE_BITS == 0) ? 1'b1 : (prescaler == '1);
    prescaler_next = (PRESCALE_BITS == 0) ? '0 : prescaler + 1'b1;
    tick_now       = en & pre_full;
    step_now       = ~en & step;
    dwell_done     = (dwell == DWELL_LAST);
    next_idx       = phase_idx;
    wraps          = 1'b0;
    if (dir) begin
      next_idx = (phase_idx == '0) ? LAST_IDX : phase_idx - 1'b1;
      wraps    = (phase_idx == '0);
    end else begin
      next_idx = (phase_idx == LAST_IDX) ? '0 : phase_idx + 1'b1;
      wraps    = (phase_idx == LAST_IDX);
    end
  end

  // All state lives here. tick and the advance share the same edge so the new
  // phase appears in the cycle that tick is high. A step only exists while en
  // is low, so it can never collide with a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      dwell     <= '0;
      phase_idx <= '0;
      phase_out <= PHASE0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
`ifdef PHASE_SEQ_BLANK_EN
      blank     <= 1'b0;
`endif
    end else begin
      tick <= tick_now;
      wrap <= 1'b0;
      if (en) begin
        prescaler <= prescaler_next;
      end
`ifdef PHASE_SEQ_BLANK_EN
      // The blank tick does not count towards the dwell, so a phase lasts
      // DWELL_TICKS + 1 ticks in total.
      if (tick_now) begin
        if (blank) begin
          blank     <= 1'b0;
          phase_out <= onehot(phase_idx);
        end else if (dwell_done) begin
          dwell     <= '0;
          phase_idx <= next_idx;
          phase_out <= '0;
          blank     <= 1'b1;
          wrap      <= wraps;
        end else begin
          dwell <= dwell + 1'b1;
        end
      end else if (step_now) begin
        // A step while blanked only ends the blank.
        if (blank) begin
          blank     <= 1'b0;
          phase_out <= onehot(phase_idx);
        end else begin
          prescaler <= '0;
          dwell     <= '0;
          phase_idx <= next_idx;
          phase_out <= '0;
          blank     <= 1'b1;
          wrap      <= wraps;
        end
      end
`else
      if (tick_now) begin
        if (dwell_done) begin
          dwell     <= '0;
          phase_idx <= next_idx;
          phase_out <= onehot(next_idx);
          wrap      <= wraps;
        end else begin
          dwell <= dwell + 1'b1;
        end
      end else if (step_now) begin
        prescaler <= '0;
        dwell     <= '0;
        phase_idx <= next_idx;
        phase_out <= onehot(next_idx);
        wrap      <= wraps;
      end
`endif
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//
// Self-checking bench for phase_sequencer. A small-parameter instance
// (PRESCALE_BITS=2, NUM_PHASES=3, DWELL_TICKS=2) is driven by directed and
// randomized steps and compared every cycle against an arithmetic reference
// model; a default-parameter instance checks the first-advance latency and
// that step is ignored while enabled.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

  localparam int PB    = 2;
  localparam int NP    = 3;
  localparam int DW    = 2;
  localparam int IDX_W = $clog2(NP);
  localparam int PMAX  = (1 << PB) - 1;

`ifdef PHASE_SEQ_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif

  // Cycle (counted from reset release, running forward) of the first wrap.
  localparam int FIRST_WRAP = (1 << PB) * (NP * DW + (NP - 1) * BLANK);

  logic            clk;
  logic            rst;
  logic            en;
  logic            dir;
  logic            step;
  logic [NP-1:0]   phase_out;
  logic [IDX_W-1:0] phase_idx;
  logic            tick;
  logic            wrap;

  logic            en_def;
  logic            dir_def;
  logic            step_def;
  logic [2:0]      phase_out_def;
  logic [1:0]      phase_idx_def;
  logic            tick_def;
  logic            wrap_def;

  int checks;
  int errors;

  // Reference model state: plain integers following the behavioural rules.
  int m_pre;
  int m_dwell;
  int m_idx;
  int m_blank;
  int m_tick;
  int m_wrap;

  phase_sequencer #(
    .PRESCALE_BITS(PB),
    .NUM_PHASES   (NP),
    .DWELL_TICKS  (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .step     (step),
    .phase_out(phase_out),
    .phase_idx(phase_idx),
    .tick     (tick),
    .wrap     (wrap)
  );

  phase_sequencer dut_def (
    .clk      (clk),
    .rst      (rst),
    .en       (en_def),
    .dir      (dir_def),
    .step     (step_def),
    .phase_out(phase_out_def),
    .phase_idx(phase_idx_def),
    .tick     (tick_def),
    .wrap     (wrap_def)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    m_pre   = 0;
    m_dwell = 0;
    m_idx   = 0;
    m_blank = 0;
    m_tick  = 0;
    m_wrap  = 0;
  endtask

  task automatic modelAdvance(input logic d);
    m_wrap  = d ? int'(m_idx == 0) : int'(m_idx == NP - 1);
    m_idx   = (m_idx + (d ? NP - 1 : 1)) % NP;
    m_blank = BLANK;
  endtask

  // One clock edge of the behavioural model.
  task automatic modelClock(input logic e, input logic d, input logic s);
    m_tick = 0;
    m_wrap = 0;
    if (e) begin
      if (m_pre == PMAX) begin
        m_pre  = 0;
        m_tick = 1;
        if (m_blank != 0) begin
          m_blank = 0;
        end else if (m_dwell + 1 == DW) begin
          m_dwell = 0;
          modelAdvance(d);
        end else begin
          m_dwell = m_dwell + 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end else if (s) begin
      if (m_blank != 0) begin
        m_blank = 0;
      end else begin
        m_pre   = 0;
        m_dwell = 0;
        modelAdvance(d);
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [NP-1:0]    exp_out;
    logic [IDX_W-1:0] exp_idx;
    exp_idx = IDX_W'(m_idx);
    exp_out = (m_blank != 0) ? '0 : (NP'(1) << exp_idx);
    checks++;
    assert (phase_out === exp_out) else begin
      errors++;
      $error("[TB] FAIL %s phase_out observed=%b expected=%b", tag, phase_out, exp_out);
    end
    checks++;
    assert (phase_idx === exp_idx) else begin
      errors++;
      $error("[TB] FAIL %s phase_idx observed=%0d expected=%0d", tag, phase_idx, exp_idx);
    end
    checks++;
    assert (tick === 1'(m_tick)) else begin
      errors++;
      $error("[TB] FAIL %s tick observed=%b expected=%0d", tag, tick, m_tick);
    end
    checks++;
    assert (wrap === 1'(m_wrap)) else begin
      errors++;
      $error("[TB] FAIL %s wrap observed=%b expected=%0d", tag, wrap, m_wrap);
    end
  endtask

  // Drive inputs, take one edge, update the model and check 1 time unit later.
  task automatic applyStimulus(input logic e, input logic d, input logic s, input string tag);
    en   = e;
    dir  = d;
    step = s;
    @(posedge clk);
    modelClock(e, d, s);
    #1;
    checkOutput(tag);
  endtask

  // Assert reset between edges, check that it acts without a clock, then
  // release it just after a later edge.
  task automatic doReset();
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int first_wrap;
    int cnt;
    logic e;
    logic d;
    logic s;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    dir      = 1'b0;
    step     = 1'b0;
    en_def   = 1'b0;
    dir_def  = 1'b0;
    step_def = 1'b0;
    modelReset();

    #12;
    checkOutput("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Forward run: first wrap must land exactly at FIRST_WRAP.
    first_wrap = 0;
    for (int c = 1; c <= FIRST_WRAP + 10; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, "forward");
      if (wrap === 1'b1 && first_wrap == 0) first_wrap = c;
    end
    checks++;
    assert (first_wrap === FIRST_WRAP) else begin
      errors++;
      $error("[TB] FAIL first_wrap_cycle observed=%0d expected=%0d", first_wrap, FIRST_WRAP);
    end

    // Reverse from phase 0, then a dir toggle three cycles into a dwell.
    doReset();
    for (int c = 0; c < 3 * FIRST_WRAP / 2; c++) applyStimulus(1'b1, 1'b1, 1'b0, "reverse");
    for (int c = 0; c < 3; c++) applyStimulus(1'b1, 1'b1, 1'b0, "dir_pre");
    for (int c = 0; c < 2 * FIRST_WRAP; c++) applyStimulus(1'b1, 1'b0, 1'b0, "dir_toggle");

    // Freeze at prescaler=2, three steps, en+step together, then re-enable.
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, "freeze_pre");
    applyStimulus(1'b1, 1'b0, 1'b0, "freeze_pre");
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, 1'b0, "freeze_hold");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, "step");
      applyStimulus(1'b0, 1'b0, 1'b0, "step_gap");
    end
    applyStimulus(1'b1, 1'b0, 1'b1, "en_wins");
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 1'b0, 1'b0, "reenable");

    // Held step in reverse gives one advance per cycle.
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b1, 1'b1, "step_held");

    // Randomized run against the model.
    d = 1'b0;
    for (int c = 0; c < 800; c++) begin
      e = ($urandom_range(0, 9) != 0);
      s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) d = ~d;
      applyStimulus(e, d, s, "random");
    end

    // Default parameters: first advance 65536 cycles after reset release,
    // and a step with en=1 changes nothing.
    en_def = 1'b1;
    doReset();
    cnt = 0;
    while (cnt < 70000 && phase_idx_def == 2'd0) begin
      step_def = (cnt >= 100 && cnt < 103);
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 110) begin
        checks++;
        assert (phase_idx_def === 2'd0) else begin
          errors++;
          $error("[TB] FAIL def_step_ignored observed=%0d expected=%0d", phase_idx_def, 0);
        end
      end
    end
    step_def = 1'b0;
    checks++;
    assert (cnt === 65536) else begin
      errors++;
      $error("[TB] FAIL def_first_advance observed=%0d expected=%0d", cnt, 65536);
    end
    checks++;
    assert (phase_idx_def === 2'd1) else begin
      errors++;
      $error("[TB] FAIL def_idx observed=%0d expected=%0d", phase_idx_def, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
